// File: rtl/display_scanner.sv
// 8-digit multiplexed seven-segment driver: hex view of the syscall word or a
// decimal view of one statistics counter, chosen by a debounced mode button.
module display_scanner #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DEBOUNCE = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] hex,
  input  logic [10:0] cnt_clk,
  input  logic [10:0] cnt_i,
  input  logic [10:0] cnt_r,
  input  logic [10:0] cnt_j,
  input  logic        mode_btn,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [2:0]  mode
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  logic          btnMeta_q, btnSync_q, btnLvl_q, btnPrev_q;
  logic [DW-1:0] dbCnt_q;
  logic [SW-1:0] presc_q;
  logic [2:0]    idx_q, idx_d;
  logic          lit_q, lit_d;
  logic [2:0]    mode_q, mode_d;
  logic [7:0]    an_q, an_d, seg_q, seg_d;
  state_t        state_q;
  logic [3:0]    iter_q;
  logic [10:0]   bin_q;
  logic [15:0]   bcd_q, bcdAdj;
  logic [15:0]   dec_q, dec_d;
  logic [10:0]   cntSel;
  logic [6:0]    glyph;
  logic          terminal, advance, wrap, start;

  function automatic logic [6:0] hexSeg(input logic [3:0] n);
    case (n)
      4'h0: hexSeg = 7'h40;
      4'h1: hexSeg = 7'h79;
      4'h2: hexSeg = 7'h24;
      4'h3: hexSeg = 7'h30;
      4'h4: hexSeg = 7'h19;
      4'h5: hexSeg = 7'h12;
      4'h6: hexSeg = 7'h02;
      4'h7: hexSeg = 7'h78;
      4'h8: hexSeg = 7'h00;
      4'h9: hexSeg = 7'h10;
      4'hA: hexSeg = 7'h08;
      4'hB: hexSeg = 7'h03;
      4'hC: hexSeg = 7'h46;
      4'hD: hexSeg = 7'h21;
      4'hE: hexSeg = 7'h06;
      default: hexSeg = 7'h0E;
    endcase
  endfunction

  // The first terminal count only lights digit 0; later ones step the index.
  always_comb begin
    terminal = (presc_q == SW'(SCAN_DIV - 1));
    advance  = btnLvl_q & ~btnPrev_q;
    wrap     = terminal & lit_q & (idx_q == 3'd7);
    start    = wrap | advance;
    lit_d    = lit_q | terminal;
    idx_d    = (terminal & lit_q) ? idx_q + 3'd1 : idx_q;
    mode_d   = advance ? ((mode_q == 3'd4) ? 3'd0 : mode_q + 3'd1) : mode_q;
    if (advance)
      dec_d = '0;
    else if (state_q == DONE && !start)
      dec_d = bcd_q;
    else
      dec_d = dec_q;
    case (mode_q)
      3'd1:    cntSel = cnt_clk;
      3'd2:    cntSel = cnt_i;
      3'd3:    cntSel = cnt_r;
      3'd4:    cntSel = cnt_j;
      default: cntSel = '0;
    endcase
    bcdAdj = bcd_q;
    for (int k = 0; k < 4; k++)
      if (bcd_q[k*4 +: 4] >= 4'd5) bcdAdj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
  end

  // Segments are built from next-state values so an and seg always agree.
  always_comb begin
    glyph = 7'h7F;
    if (mode_d == 3'd0)
      glyph = hexSeg(hex[{idx_d, 2'b00} +: 4]);
    else if (idx_d == 3'd7)
      case (mode_d)
        3'd1:    glyph = 7'h46;
        3'd2:    glyph = 7'h4F;
        3'd3:    glyph = 7'h2F;
        default: glyph = 7'h61;
      endcase
    else if (!idx_d[2])
      glyph = hexSeg(dec_d[{idx_d[1:0], 2'b00} +: 4]);
    seg_d = lit_d ? {1'b1, glyph} : 8'hFF;
    an_d  = lit_d ? ~(8'd1 << idx_d) : 8'hFF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btnMeta_q <= 1'b0;
      btnSync_q <= 1'b0;
      btnLvl_q  <= 1'b0;
      btnPrev_q <= 1'b0;
      dbCnt_q   <= '0;
    end else begin
      btnMeta_q <= mode_btn;
      btnSync_q <= btnMeta_q;
      btnPrev_q <= btnLvl_q;
      if (btnSync_q != btnLvl_q) begin
        if (dbCnt_q == DW'(DEBOUNCE - 1)) begin
          btnLvl_q <= btnSync_q;
          dbCnt_q  <= '0;
        end else begin
          dbCnt_q <= dbCnt_q + DW'(1);
        end
      end else begin
        dbCnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      lit_q   <= 1'b0;
      mode_q  <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
    end else begin
      presc_q <= terminal ? '0 : presc_q + SW'(1);
      idx_q   <= idx_d;
      lit_q   <= lit_d;
      mode_q  <= mode_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  // Any start pulse restarts the conversion from LOAD, whatever state it is in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      dec_q   <= '0;
    end else begin
      dec_q <= dec_d;
      if (start) begin
        state_q <= LOAD;
      end else begin
        case (state_q)
          LOAD: begin
            bin_q   <= cntSel;
            bcd_q   <= '0;
            iter_q  <= '0;
            state_q <= SHIFT;
          end
          SHIFT: begin
            {bcd_q, bin_q} <= {bcdAdj[14:0], bin_q, 1'b0};
            iter_q         <= iter_q + 4'd1;
            if (iter_q == 4'd10) state_q <= DONE;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: a time-based reference model predicts
// an/seg/mode for every clock edge and a monitor compares on the falling edge.
module tb_display_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;
  localparam int MAXC     = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hex;
  logic [10:0] cnt_clk, cnt_i, cnt_r, cnt_j;
  logic        mode_btn;
  logic [7:0]  an, seg;
  logic [2:0]  mode;

  display_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .hex(hex),
    .cnt_clk(cnt_clk), .cnt_i(cnt_i), .cnt_r(cnt_r), .cnt_j(cnt_j),
    .mode_btn(mode_btn), .an(an), .seg(seg), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic [2:0] mode;
  } exp_t;

  exp_t expQ[$];
  int tests = 0, failed = 0, pushed = 0, popped = 0;

  // Reference model: edges since reset release, raw button history, views.
  int n = 0;
  bit rawHist[MAXC];
  bit lvl = 1'b0;
  int lastFlip = 0;
  int advAt = -1;
  int mMode = 0;
  int decVal = 0;
  int convStart = 0;
  bit convActive = 1'b0;
  int snap = 0;

  function automatic bit syncAt(int m);
    return (m >= 3) ? rawHist[m-2] : 1'b0;
  endfunction

  function automatic logic [6:0] digitCode(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic modelEdge();
    exp_t e;
    bit start, allDiff;
    int idx, div;
    if (!reset) begin
      n = 0; lvl = 1'b0; lastFlip = 0; advAt = -1;
      mMode = 0; decVal = 0; convActive = 1'b0;
      e.an = 8'hFF; e.seg = 8'hFF; e.mode = 3'd0;
    end else begin
      n++;
      if (n < MAXC) rawHist[n] = mode_btn;
      start = 1'b0;
      if (advAt == n) begin
        mMode = (mMode + 1) % 5;
        decVal = 0;
        start = 1'b1;
      end
      if (n > SCAN_DIV && (n - SCAN_DIV) % (8 * SCAN_DIV) == 0) start = 1'b1;
      if (n - lastFlip >= DEBOUNCE) begin
        allDiff = 1'b1;
        for (int m = n - DEBOUNCE + 1; m <= n; m++)
          if (syncAt(m) == lvl) allDiff = 1'b0;
        if (allDiff) begin
          lvl = !lvl;
          lastFlip = n;
          if (lvl) advAt = n + 1;
        end
      end
      if (start) begin
        convActive = 1'b1;
        convStart = n;
      end else if (convActive) begin
        if (n == convStart + 1)
          case (mMode)
            1: snap = int'(cnt_clk);
            2: snap = int'(cnt_i);
            3: snap = int'(cnt_r);
            4: snap = int'(cnt_j);
            default: snap = 0;
          endcase
        if (n == convStart + 13) begin
          decVal = snap;
          convActive = 1'b0;
        end
      end
      e.mode = 3'(mMode);
      if (n < SCAN_DIV) begin
        e.an = 8'hFF; e.seg = 8'hFF;
      end else begin
        idx = ((n - SCAN_DIV) / SCAN_DIV) % 8;
        e.an = ~(8'd1 << idx);
        if (mMode == 0)
          e.seg = {1'b1, digitCode(int'((hex >> (4 * idx)) & 32'hF))};
        else if (idx == 7)
          case (mMode)
            1: e.seg = 8'hC6;
            2: e.seg = 8'hCF;
            3: e.seg = 8'hAF;
            default: e.seg = 8'hE1;
          endcase
        else if (idx >= 4)
          e.seg = 8'hFF;
        else begin
          div = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
          e.seg = {1'b1, digitCode((decVal / div) % 10)};
        end
      end
    end
    expQ.push_back(e);
    pushed++;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      popped++;
      checkOutput("an", an, e.an);
      checkOutput("seg", seg, e.seg);
      checkOutput("mode", {5'd0, mode}, {5'd0, e.mode});
    end
  end

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) tick();
  endtask

  task automatic press(input int hold, input int rel);
    mode_btn = 1'b1;
    applyStimulus(hold);
    mode_btn = 1'b0;
    applyStimulus(rel);
  endtask

  initial begin
    reset = 1'b0; mode_btn = 1'b0; hex = $urandom;
    cnt_clk = '0; cnt_i = '0; cnt_r = '0; cnt_j = '0;
    applyStimulus(3);
    reset = 1'b1;
    applyStimulus(40);

    hex = 32'h1234ABCD;
    applyStimulus(40);
    for (int i = 0; i < 10; i++) begin
      hex = $urandom;
      applyStimulus(4);
    end

    cnt_clk = 11'd2047;
    press(12, 12);
    applyStimulus(40);

    for (int i = 0; i < 14; i++) begin
      mode_btn = ~mode_btn;
      applyStimulus(3);
    end
    mode_btn = 1'b1;
    applyStimulus(20);
    mode_btn = 1'b0;
    applyStimulus(20);

    cnt_i = 11'd5; cnt_r = 11'd999; cnt_j = 11'd0;
    for (int i = 0; i < 5; i++) press(12, 12);
    press(12, 12);
    press(12, 6);
    press(11, 40);

    mode_btn = 1'b1;
    applyStimulus(14);
    mode_btn = 1'b0;
    applyStimulus(4);
    reset = 1'b0;
    mode_btn = 1'b1;
    #1;
    checkOutput("async_an", an, 8'hFF);
    checkOutput("async_seg", seg, 8'hFF);
    checkOutput("async_mode", {5'd0, mode}, 8'd0);
    applyStimulus(3);
    reset = 1'b1;
    applyStimulus(20);
    mode_btn = 1'b0;
    applyStimulus(20);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 14) == 0) mode_btn = ~mode_btn;
      if ($urandom_range(0, 9) == 0) hex = $urandom;
      if ($urandom_range(0, 49) == 0) cnt_clk = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 49) == 0) cnt_i = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 49) == 0) cnt_r = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 49) == 0) cnt_j = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 699) == 0) begin
        reset = 1'b0;
        applyStimulus(2);
        reset = 1'b1;
      end
      applyStimulus(1);
    end

    #20;
    tests++;
    if (pushed != popped || pushed == 0) begin
      failed++;
      $display("[TB] FAIL drain: popped %0d expected %0d", popped, pushed);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
